// File: rtl/ffcp_commit_reader_pkg.sv
// Shared constants and state type for the FFCP commit reader.
// Payload length, index width and packet-buffer partition geometry live here.
package ffcp_commit_reader_pkg;

   localparam int unsigned FFCP_DATA_LEN    = 769;
   localparam int unsigned FFCP_INDEX_LEN   = 6;
   localparam int unsigned BYTE_LEN         = 8;
   localparam int unsigned PB_PART_ADDR_LEN = 10;
   localparam int unsigned PB_RAM_LATENCY   = 2;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StDrain = 2'd2
   } state_t;

endpackage

// File: rtl/ffcp_valid_pipe.sv
// Fixed-depth shift register with asynchronous active-low clear.
// Carries per-read sideband flags alongside the packet-buffer read latency.
module ffcp_valid_pipe #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [DEPTH-1:0][WIDTH-1:0] r_stage;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stage <= '0;
      end else begin
         for (int unsigned i = DEPTH - 1; i > 0; i--) begin
            r_stage[i] <= r_stage[i-1];
         end
         r_stage[0] <= i_d;
      end
   end

   assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/ffcp_commit_reader.sv
// Streams one committed packet-buffer partition's payload to the DMA pipeline,
// one byte per downstream request, and signals completion back to the rx server.
module ffcp_commit_reader
   import ffcp_commit_reader_pkg::*;
#(
   parameter int unsigned DATA_LEN      = FFCP_DATA_LEN,
   parameter int unsigned INDEX_LEN     = FFCP_INDEX_LEN,
   parameter int unsigned PART_ADDR_LEN = PB_PART_ADDR_LEN,
   parameter int unsigned RAM_LATENCY   = PB_RAM_LATENCY
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_commit,
   input  logic [INDEX_LEN-1:0]               i_commit_index,
   input  logic                               i_readclk,
   output logic                               o_ram_rden,
   output logic [INDEX_LEN+PART_ADDR_LEN-1:0] o_ram_addr,
   input  logic [BYTE_LEN-1:0]                i_ram_data,
   output logic                               o_outclk,
   output logic [BYTE_LEN-1:0]                o_out,
   output logic                               o_commit_done,
   output logic                               o_busy,
   output logic                               o_overrun
);

   localparam logic [PART_ADDR_LEN-1:0] LastCnt = PART_ADDR_LEN'(DATA_LEN - 1);

   state_t                   r_state, w_state_d;
   logic [INDEX_LEN-1:0]     r_idx, w_idx_d;
   logic [PART_ADDR_LEN-1:0] r_cnt, w_cnt_d;
   logic                     r_overrun, w_overrun_d;

   logic       w_read;
   logic       w_last_rd;
   logic [1:0] w_pipe_q;
   logic       w_valid;
   logic       w_last;

   assign w_read    = (r_state == StRead) && i_readclk;
   assign w_last_rd = w_read && (r_cnt == LastCnt);

   ffcp_valid_pipe #(
      .WIDTH (2),
      .DEPTH (RAM_LATENCY)
   ) u_valid_pipe (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     ({w_read, w_last_rd}),
      .o_q     (w_pipe_q)
   );

   assign w_valid = w_pipe_q[1];
   assign w_last  = w_pipe_q[0];

   assign o_ram_rden    = w_read;
   assign o_ram_addr    = w_read ? {r_idx, r_cnt} : '0;
   assign o_outclk      = w_valid;
   assign o_out         = w_valid ? i_ram_data : '0;
   assign o_commit_done = w_valid && w_last;
   assign o_busy        = (r_state != StIdle);
   assign o_overrun     = r_overrun;

   always_comb begin
      w_state_d   = r_state;
      w_idx_d     = r_idx;
      w_cnt_d     = r_cnt;
      w_overrun_d = r_overrun;
      case (r_state)
         StIdle: begin
            if (i_commit) begin
               w_idx_d   = i_commit_index;
               w_cnt_d   = '0;
               w_state_d = StRead;
            end
         end
         StRead: begin
            if (w_read) begin
               w_cnt_d = r_cnt + 1'b1;
               if (w_last_rd) w_state_d = StDrain;
            end
            if (i_commit) w_overrun_d = 1'b1;
         end
         StDrain: begin
            // A commit landing on the completion cycle is the one accepted while busy.
            if (o_commit_done) begin
               if (i_commit) begin
                  w_idx_d   = i_commit_index;
                  w_cnt_d   = '0;
                  w_state_d = StRead;
               end else begin
                  w_state_d = StIdle;
               end
            end else if (i_commit) begin
               w_overrun_d = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= StIdle;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_idx     <= w_idx_d;
         r_cnt     <= w_cnt_d;
         r_overrun <= w_overrun_d;
      end
   end

endmodule

// File: tb/tb_ffcp_commit_reader.sv
// Self-checking bench for ffcp_commit_reader: reference model plus expected-byte scoreboard,
// with a 2-cycle RAM model returning addr[7:0] ^ addr[15:8].
module tb_ffcp_commit_reader;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_commit = 1'b0;
   logic [5:0]  i_commit_index = '0;
   logic        i_readclk = 1'b0;
   logic        o_ram_rden;
   logic [15:0] o_ram_addr;
   logic [7:0]  i_ram_data;
   logic        o_outclk;
   logic [7:0]  o_out;
   logic        o_commit_done;
   logic        o_busy;
   logic        o_overrun;

   ffcp_commit_reader u_dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_commit       (i_commit),
      .i_commit_index (i_commit_index),
      .i_readclk      (i_readclk),
      .o_ram_rden     (o_ram_rden),
      .o_ram_addr     (o_ram_addr),
      .i_ram_data     (i_ram_data),
      .o_outclk       (o_outclk),
      .o_out          (o_out),
      .o_commit_done  (o_commit_done),
      .o_busy         (o_busy),
      .o_overrun      (o_overrun)
   );

   initial forever #5 i_clk = ~i_clk;

   function automatic logic [7:0] ram_f(input logic [15:0] a);
      return a[7:0] ^ a[15:8];
   endfunction

   logic [7:0] ram_p0, ram_p1;
   always @(posedge i_clk) begin
      ram_p0 <= o_ram_rden ? ram_f(o_ram_addr) : 8'bx;
      ram_p1 <= ram_p0;
   end
   assign i_ram_data = ram_p1;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic       last;
      int         stamp;
   } exp_t;
   exp_t sb[$];

   // Reference model state: 0 idle, 1 read, 2 drain
   int          m_state = 0;
   logic [5:0]  m_idx = '0;
   int          m_cnt = 0;
   logic        m_overrun = 1'b0;

   int          n_done = 0;
   int          pkt_out = 0;
   int          pkt_reads = 0;
   int          n_dut_rden = 0;
   int          first_out_cyc = 0;
   int          last_out_cyc = 0;
   logic [15:0] first_addr = '0;
   logic [15:0] last_addr = '0;

   initial begin
      forever begin
         @(negedge i_clk);
         if (o_ram_rden === 1'b1) n_dut_rden++;
         if (!i_rst_n) begin
            chk("rst_outclk", o_outclk, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_commit_done, 0);
            chk("rst_rden", o_ram_rden, 0);
            chk("rst_overrun", o_overrun, 0);
            m_state   = 0;
            m_cnt     = 0;
            m_overrun = 1'b0;
            sb.delete();
         end else begin
            logic exp_rden, exp_out, done_exp;
            logic [15:0] a;
            exp_t e;
            exp_rden = (m_state == 1) && i_readclk;
            exp_out  = (sb.size() > 0) && (sb[0].stamp + 2 == cyc);
            done_exp = 1'b0;
            chk("outclk", o_outclk, exp_out);
            if (exp_out) begin
               e = sb.pop_front();
               chk("out_byte", o_out, e.data);
               chk("commit_done", o_commit_done, e.last);
               done_exp = e.last;
               if (pkt_out == 0) first_out_cyc = cyc;
               last_out_cyc = cyc;
               pkt_out++;
               if (e.last) n_done++;
            end else begin
               chk("out_quiet", o_out, 0);
               chk("done_quiet", o_commit_done, 0);
            end
            chk("rden", o_ram_rden, exp_rden);
            if (exp_rden) begin
               a = {m_idx, 10'(m_cnt)};
               chk("addr", o_ram_addr, a);
               sb.push_back('{data: ram_f(a), last: (m_cnt == 768), stamp: cyc});
               if (pkt_reads == 0) first_addr = a;
               last_addr = a;
               pkt_reads++;
            end
            chk("busy", o_busy, (m_state != 0));
            chk("overrun", o_overrun, m_overrun);
            case (m_state)
               0: if (i_commit) begin m_state = 1; m_idx = i_commit_index; m_cnt = 0; end
               1: begin
                  if (exp_rden) begin
                     if (m_cnt == 768) m_state = 2;
                     m_cnt++;
                  end
                  if (i_commit) m_overrun = 1'b1;
               end
               default: begin
                  if (done_exp) begin
                     if (i_commit) begin m_state = 1; m_idx = i_commit_index; m_cnt = 0; end
                     else m_state = 0;
                  end else if (i_commit) begin
                     m_overrun = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clr_pkt();
      pkt_out   = 0;
      pkt_reads = 0;
   endtask

   // Commit idx, then request bytes on a 1-of-duty pattern until commit_done.
   // intr_k >= 0 pulses a second commit (intr_idx) at that stream cycle.
   task automatic run_pkt(input logic [5:0] idx, input int duty, input int intr_k,
                          input logic [5:0] intr_idx, input int bound);
      int start;
      bit ok;
      start = n_done;
      ok = 0;
      i_commit = 1'b1;
      i_commit_index = idx;
      i_readclk = 1'b0;
      tick();
      i_commit = 1'b0;
      for (int k = 0; k < bound; k++) begin
         i_readclk = (k % duty == 0);
         if (k == intr_k) begin
            i_commit = 1'b1;
            i_commit_index = intr_idx;
         end else begin
            i_commit = 1'b0;
         end
         tick();
         if (n_done != start) begin
            ok = 1;
            break;
         end
      end
      i_commit = 1'b0;
      if (!ok) chk("timeout", 0, 1);
   endtask

   initial begin
      int d0, r0;
      bit issued, ok;

      // Reset state
      #1;
      chk("reset_outclk", o_outclk, 0);
      chk("reset_busy", o_busy, 0);
      chk("reset_rden", o_ram_rden, 0);
      chk("reset_overrun", o_overrun, 0);
      repeat (3) tick();
      i_rst_n = 1'b1;
      tick();

      // 1: idx 5, readclk held high
      clr_pkt();
      run_pkt(6'd5, 1, -1, 6'd0, 2000);
      chk("t1_busy_after", o_busy, 0);
      chk("t1_count", pkt_out, 769);
      chk("t1_first_addr", first_addr, 5120);
      chk("t1_last_addr", last_addr, 5888);
      chk("t1_contiguous", last_out_cyc - first_out_cyc, 768);
      i_readclk = 1'b0;
      tick();

      // 2: idx 63, readclk 1-of-3
      clr_pkt();
      run_pkt(6'd63, 3, -1, 6'd0, 4000);
      chk("t2_count", pkt_out, 769);
      chk("t2_first_addr", first_addr, 64512);
      chk("t2_last_addr", last_addr, 65280);
      i_readclk = 1'b0;
      tick();

      // 3: commit while reading is dropped and flags overrun
      clr_pkt();
      run_pkt(6'd1, 1, 10, 6'd2, 2000);
      chk("t3_count", pkt_out, 769);
      chk("t3_last_addr", last_addr, 1792);
      chk("t3_overrun", o_overrun, 1);
      i_readclk = 1'b0;
      repeat (5) tick();
      chk("t3_idle_busy", o_busy, 0);

      // 4: commit in the commit_done cycle is accepted
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      tick();
      chk("t4_overrun_cleared", o_overrun, 0);
      clr_pkt();
      d0 = n_done;
      issued = 0;
      ok = 0;
      i_commit = 1'b1;
      i_commit_index = 6'd8;
      tick();
      i_commit = 1'b0;
      i_readclk = 1'b1;
      for (int k = 0; k < 4000; k++) begin
         tick();
         if (o_commit_done && !issued) begin
            i_commit = 1'b1;
            i_commit_index = 6'd9;
            issued = 1;
         end else begin
            i_commit = 1'b0;
         end
         if (n_done == d0 + 2) begin
            ok = 1;
            break;
         end
      end
      i_commit = 1'b0;
      if (!ok) chk("t4_timeout", 0, 1);
      chk("t4_count", pkt_out, 1538);
      chk("t4_last_addr", last_addr, 9984);
      chk("t4_overrun", o_overrun, 0);
      i_readclk = 1'b0;
      tick();

      // 5: reset at byte 300 aborts, then a fresh commit streams fully
      clr_pkt();
      d0 = n_done;
      ok = 0;
      i_commit = 1'b1;
      i_commit_index = 6'd4;
      tick();
      i_commit = 1'b0;
      i_readclk = 1'b1;
      for (int k = 0; k < 2000; k++) begin
         tick();
         if (pkt_out >= 300) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("t5_timeout", 0, 1);
      i_rst_n = 1'b0;
      #1;
      chk("t5_rst_outclk", o_outclk, 0);
      chk("t5_rst_busy", o_busy, 0);
      chk("t5_rst_done", o_commit_done, 0);
      repeat (3) tick();
      i_rst_n = 1'b1;
      i_readclk = 1'b0;
      tick();
      chk("t5_no_done_on_abort", n_done, d0);
      clr_pkt();
      run_pkt(6'd0, 1, -1, 6'd0, 2000);
      chk("t5_count", pkt_out, 769);
      chk("t5_first_addr", first_addr, 0);
      chk("t5_last_addr", last_addr, 768);
      chk("t5_done_once", n_done, d0 + 1);

      // 6: readclk held while idle never reads
      r0 = n_dut_rden;
      clr_pkt();
      i_readclk = 1'b1;
      repeat (10) tick();
      chk("t6_no_rden", n_dut_rden, r0);
      chk("t6_no_out", pkt_out, 0);
      i_readclk = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
